// File: rtl/mips_multicycle_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : mips_multicycle_ctrl_pkg
// Brief   : State encodings, opcode/funct constants, ALU codes and the
//           control-word type shared by the multicycle MIPS controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_multicycle_ctrl_pkg;

    localparam int c_state_w = 4;

    localparam logic [c_state_w-1:0] c_st_idle   = 4'd0;
    localparam logic [c_state_w-1:0] c_st_fetch  = 4'd1;
    localparam logic [c_state_w-1:0] c_st_decode = 4'd2;
    localparam logic [c_state_w-1:0] c_st_memadr = 4'd3;
    localparam logic [c_state_w-1:0] c_st_memrd  = 4'd4;
    localparam logic [c_state_w-1:0] c_st_memwb  = 4'd5;
    localparam logic [c_state_w-1:0] c_st_memwr  = 4'd6;
    localparam logic [c_state_w-1:0] c_st_rtype  = 4'd7;
    localparam logic [c_state_w-1:0] c_st_aluwb  = 4'd8;
    localparam logic [c_state_w-1:0] c_st_addiex = 4'd9;
    localparam logic [c_state_w-1:0] c_st_addiwb = 4'd10;
    localparam logic [c_state_w-1:0] c_st_branch = 4'd11;
    localparam logic [c_state_w-1:0] c_st_jump   = 4'd12;
    localparam logic [c_state_w-1:0] c_st_trap   = 4'd13;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    localparam logic [1:0] c_pcsrc_alu  = 2'd0;
    localparam logic [1:0] c_pcsrc_aluo = 2'd1;
    localparam logic [1:0] c_pcsrc_jump = 2'd2;

    localparam logic [1:0] c_srcb_b    = 2'd0;
    localparam logic [1:0] c_srcb_four = 2'd1;
    localparam logic [1:0] c_srcb_imm  = 2'd2;
    localparam logic [1:0] c_srcb_br   = 2'd3;

    // Per-state decode; pc_write_cond is qualified by the branch condition later.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_en;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == c_op_lw) || (op == c_op_sw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_alu_decoder.sv
//------------------------------------------------------------------------------
// Module  : mips_alu_decoder
// Brief   : Combinational map of (alu_op, funct) to alu_ctrl plus funct_illegal.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_alu_decoder
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       funct_illegal
);

    always_comb begin : p_decode
        alu_ctrl      = 4'b0000;
        funct_illegal = 1'b0;
        case (alu_op)
            c_aluop_add: alu_ctrl = c_alu_add;
            c_aluop_sub: alu_ctrl = c_alu_sub;
            c_aluop_funct: begin
                case (funct)
                    c_fn_add: alu_ctrl = c_alu_add;
                    c_fn_sub: alu_ctrl = c_alu_sub;
                    c_fn_and: alu_ctrl = c_alu_and;
                    c_fn_or:  alu_ctrl = c_alu_or;
                    c_fn_slt: alu_ctrl = c_alu_slt;
                    default:  funct_illegal = 1'b1;
                endcase
            end
            default: alu_ctrl = 4'b0000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module  : mips_multicycle_ctrl
// Brief   : Moore main-control FSM for a multicycle MIPS datapath, with an
//           instruction-retired strobe and an illegal-instruction trap.
//           Define MIPS_CTRL_BNE_EN to add bne support.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic [31:0] pc_reset_val,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic        instr_done,
    output logic        illegal,
    output logic [3:0]  state
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next_state;
    ctrl_t                w_ctrl;
    logic [3:0]           w_dec_alu_ctrl;
    logic                 w_funct_illegal;
    logic                 w_branch_cond;

    mips_alu_decoder u_alu_decoder (
        .alu_op        (w_ctrl.alu_op),
        .funct         (funct),
        .alu_ctrl      (w_dec_alu_ctrl),
        .funct_illegal (w_funct_illegal)
    );

`ifdef MIPS_CTRL_BNE_EN
    logic r_is_bne;

    // IR is stable after FETCH, so the branch sense is latched once in DECODE.
    always_ff @(posedge clk or posedge reset) begin : p_is_bne
        if (reset) begin
            r_is_bne <= 1'b0;
        end else if (r_state == c_st_decode) begin
            r_is_bne <= (opcode == c_op_bne);
        end
    end

    assign w_branch_cond = r_is_bne ? ~zero : zero;
`else
    assign w_branch_cond = zero;
`endif

    always_ff @(posedge clk or posedge reset) begin : p_state
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin : p_next
        w_next_state = r_state;
        case (r_state)
            c_st_idle:   w_next_state = c_st_fetch;
            c_st_fetch:  w_next_state = c_st_decode;
            c_st_decode: begin
                case (opcode)
                    c_op_rtype:     w_next_state = c_st_rtype;
                    c_op_lw,
                    c_op_sw:        w_next_state = c_st_memadr;
                    c_op_addi:      w_next_state = c_st_addiex;
                    c_op_beq:       w_next_state = c_st_branch;
`ifdef MIPS_CTRL_BNE_EN
                    c_op_bne:       w_next_state = c_st_branch;
`endif
                    c_op_j:         w_next_state = c_st_jump;
                    default:        w_next_state = c_st_trap;
                endcase
            end
            c_st_memadr: w_next_state = (is_mem_op(opcode) && opcode == c_op_sw)
                                        ? c_st_memwr : c_st_memrd;
            c_st_memrd:  w_next_state = c_st_memwb;
            c_st_memwb:  w_next_state = c_st_fetch;
            c_st_memwr:  w_next_state = c_st_fetch;
            c_st_rtype:  w_next_state = w_funct_illegal ? c_st_trap : c_st_aluwb;
            c_st_aluwb:  w_next_state = c_st_fetch;
            c_st_addiex: w_next_state = c_st_addiwb;
            c_st_addiwb: w_next_state = c_st_fetch;
            c_st_branch: w_next_state = c_st_fetch;
            c_st_jump:   w_next_state = c_st_fetch;
            c_st_trap:   w_next_state = c_st_trap;
            default:     w_next_state = c_st_trap;
        endcase
    end

    always_comb begin : p_out
        w_ctrl = '0;
        case (r_state)
            c_st_fetch: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.ir_write  = 1'b1;
                w_ctrl.alu_src_b = c_srcb_four;
                w_ctrl.alu_en    = 1'b1;
                w_ctrl.alu_op    = c_aluop_add;
                w_ctrl.pc_src    = c_pcsrc_alu;
                w_ctrl.pc_write  = 1'b1;
            end
            c_st_decode: begin
                w_ctrl.alu_src_b = c_srcb_br;
                w_ctrl.alu_en    = 1'b1;
                w_ctrl.alu_op    = c_aluop_add;
            end
            c_st_memadr, c_st_addiex: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_imm;
                w_ctrl.alu_en    = 1'b1;
                w_ctrl.alu_op    = c_aluop_add;
            end
            c_st_memrd: begin
                w_ctrl.iord     = 1'b1;
                w_ctrl.mem_read = 1'b1;
            end
            c_st_memwb: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            c_st_memwr: begin
                w_ctrl.iord       = 1'b1;
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            c_st_rtype: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_b;
                w_ctrl.alu_en    = 1'b1;
                w_ctrl.alu_op    = c_aluop_funct;
            end
            c_st_aluwb: begin
                w_ctrl.reg_dst    = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            c_st_addiwb: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            c_st_branch: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = c_srcb_b;
                w_ctrl.alu_en        = 1'b1;
                w_ctrl.alu_op        = c_aluop_sub;
                w_ctrl.pc_src        = c_pcsrc_aluo;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.instr_done    = 1'b1;
            end
            c_st_jump: begin
                w_ctrl.pc_src     = c_pcsrc_jump;
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            c_st_trap: begin
                w_ctrl.illegal = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign pc_en        = w_ctrl.pc_write | (w_ctrl.pc_write_cond & w_branch_cond);
    assign pc_src       = w_ctrl.pc_src;
    assign pc_reset_val = RESET_PC;
    assign iord         = w_ctrl.iord;
    assign mem_read     = w_ctrl.mem_read;
    assign mem_write    = w_ctrl.mem_write;
    assign ir_write     = w_ctrl.ir_write;
    assign reg_dst      = w_ctrl.reg_dst;
    assign mem_to_reg   = w_ctrl.mem_to_reg;
    assign reg_write    = w_ctrl.reg_write;
    assign alu_src_a    = w_ctrl.alu_src_a;
    assign alu_src_b    = w_ctrl.alu_src_b;
    assign alu_ctrl     = w_ctrl.alu_en ? w_dec_alu_ctrl : 4'b0000;
    assign instr_done   = w_ctrl.instr_done;
    assign illegal      = w_ctrl.illegal;
    assign state        = r_state;

endmodule

`default_nettype wire
